// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter run controller.
// COUNTER_CTRL_PRESCALE_EN selects the prescaled step rate in the controller.
package counter_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/counter_run_controller_if.sv
// Command handshake, run controls and status outputs of the counter run controller.
// master = requester side, slave = controller side.
interface counter_run_controller_if
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_end;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             wrap;

    modport master (
        output cmd_valid, cmd_dir, cmd_start, cmd_end, pause, abort,
        input  cmd_ready, out, busy, done, aborted, wrap
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_start, cmd_end, pause, abort,
        output cmd_ready, out, busy, done, aborted, wrap
    );
endinterface

// File: rtl/tick_prescaler.sv
// Step-rate divider: tick is high one cycle in every PRESCALE; clear restarts the period.
// Only compiled when COUNTER_CTRL_PRESCALE_EN is defined.
`ifdef COUNTER_CTRL_PRESCALE_EN
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick on the last count of the period, so the first step lands PRESCALE edges after clear.
    assign tick = (cnt_q == LAST);
endmodule
`endif

// File: rtl/counter_run_controller.sv
// Bounded up/down count run sequencer with pause, abort and done/aborted/wrap pulses.
// Define COUNTER_CTRL_PRESCALE_EN to step once every PRESCALE cycles instead of every cycle.
module counter_run_controller
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    counter_run_controller_if.slave  bus
);
    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             wrap_q, wrap_d;

    logic accept;
    logic at_end;
    logic tick;

    assign accept = (state_q == IDLE) && bus.cmd_valid;
    assign at_end = (out_q == end_q);

`ifdef COUNTER_CTRL_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .hold  (bus.pause),
        .tick  (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (bus.abort || at_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs: priority is abort, then terminal check, then pause, then step.
    always_comb begin
        dir_d     = dir_q;
        end_d     = end_q;
        out_d     = out_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        wrap_d    = 1'b0;
        if (accept) begin
            out_d = bus.cmd_start;
            dir_d = bus.cmd_dir;
            end_d = bus.cmd_end;
        end else if (state_q == RUN) begin
            if (bus.abort) begin
                aborted_d = 1'b1;
            end else if (at_end) begin
                done_d = 1'b1;
            end else if (!bus.pause && tick) begin
                if (dir_q == DIR_UP) begin
                    out_d  = out_q + WIDTH'(1);
                    wrap_d = (out_q == '1);
                end else begin
                    out_d  = out_q - WIDTH'(1);
                    wrap_d = (out_q == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q     <= DIR_UP;
            end_q     <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            end_q     <= end_d;
            out_q     <= out_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out       = out_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: doc/counter_run_controller.md
Name: counter_run_controller

Overview:
- Sequencer for the team's 3-bit counter datapath.
- Accepts a run command (direction, start value, end value) over a valid/ready handshake, then steps an internal synchronous count from start to end with modulo wrap-around.
- Supports pause and abort, and signals completion with a one-cycle done pulse.
- Replaces free-running ripple counting wherever the system needs bounded, restartable count runs.

Parameters:
- WIDTH, 3, count width in bits; count wraps modulo 2^WIDTH.
- PRESCALE, 4, step period in clock cycles. Used only when COUNTER_CTRL_PRESCALE_EN is defined; must be >= 1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_dir  input  1  0 = count up, 1 = count down.
- cmd_start  input  WIDTH  initial count.
- cmd_end  input  WIDTH  terminal count.
- pause  input  1  level; holds the count while high in RUN.
- abort  input  1  level; terminates the run without done.
- out  output  WIDTH  current count.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on abort.
- wrap  output  1  one-cycle pulse when a step crosses the modulo boundary.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - out=0, busy=0, done=0, aborted=0, wrap=0, cmd_ready=1.
  - Captured dir/end registers cleared.
  - Reset mid-run discards the run with no done/aborted pulse.
- States: IDLE, RUN. Registered outputs; done, aborted and wrap are registered pulses lasting exactly one cycle.
- IDLE:
  - cmd_ready=1. Accept on the edge where cmd_valid && cmd_ready.
  - On accept: out <= cmd_start; capture dir and end; state <= RUN; busy <= 1; cmd_ready <= 0.
  - pause and abort are ignored in IDLE.
  - out holds its last value in IDLE.
- RUN, evaluated on each edge in this priority:
  1. abort=1: state <= IDLE; aborted pulse; out holds; no done.
  2. out == end: state <= IDLE; done pulse; out holds end. The terminal check overrides pause.
  3. pause=1: out holds.
  4. Otherwise step: out <= out+1 (up) or out-1 (down), modulo 2^WIDTH. Assert wrap when the step goes 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down).
- cmd_valid while in RUN is not accepted (cmd_ready=0). The requester holds it until IDLE.
- Latency, no pause: the done pulse appears N+1 edges after the accept edge, where N = (end-start) mod 2^WIDTH for up, or (start-end) mod 2^WIDTH for down.
- start == end: done one edge after accept, zero steps.
- A new command may be accepted on the edge after done/aborted (cmd_ready=1 in the pulse cycle). Back-to-back accept while the done pulse is high is legal.
- All arithmetic is unsigned WIDTH-bit; no saturation.

Optional Feature:
- Macro: COUNTER_CTRL_PRESCALE_EN.
- Defined:
  - Steps occur only on a tick asserted once every PRESCALE cycles.
  - The tick counter clears on accept, so the first step happens PRESCALE edges after accept.
  - abort and the terminal check are evaluated every cycle, not only on ticks.
  - pause freezes the tick counter.
- Undefined: the tick is constant 1 (one step per cycle); PRESCALE is unused and no prescaler logic is instantiated.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state typedef {IDLE, RUN};
  - direction constants DIR_UP=0, DIR_DOWN=1;
  - default WIDTH constant.
- Sub-module tick_prescaler (inputs: clk, rst, clear, hold; output: tick):
  - instantiated only under COUNTER_CTRL_PRESCALE_EN;
  - otherwise tick is tied high.

Test Plan:
- Reset: assert rst=0 mid-run at out=5 -> out=0, busy=0, cmd_ready=1 immediately (asynchronous), no done/aborted pulse.
- Up run with wrap: dir=0, start=6, end=1 -> out sequence 6,7,0,1; wrap pulse on the 7->0 step; done 4 edges after accept.
- Down run: dir=1, start=3, end=0 -> out 3,2,1,0; done 4 edges after accept; no wrap. Then start=0, end=6 down -> wrap on the 0->7 step.
- Zero-length run: start=end=4 -> done on the first edge after accept; out stays 4; busy high exactly one cycle.
- Pause/abort:
  - start=0, end=7 up; pause for 3 cycles at out=2 -> out holds 2; done delayed by 3 cycles.
  - Repeat with abort at out=4 -> aborted pulse; out=4; no done.
  - pause held while out==end -> done still fires.
- Handshake and prescale:
  - cmd_valid held during RUN -> not accepted until the done cycle; accepted on the next edge.
  - With COUNTER_CTRL_PRESCALE_EN and PRESCALE=4, run 0->2 up -> steps at edges 4 and 8 after accept; done at edge 9.
